// File: rtl/seg7_pkg.sv
// Shared constants for the eight-digit seven-segment scanner: blank patterns,
// the active-low segment table and the frame snapshot record.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Active-low {g,f,e,d,c,b,a} encodings for 0-9, A, b, C, d, E, F
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [7:0][3:0] dig;
    logic [7:0]      dp_mask;
    logic            lz_en;
  } shadow_t;

endpackage

// File: rtl/seg7_scan_if.sv
// Digit-value inputs and display pin outputs of the scanner, bundled.
interface seg7_scan_if;
  logic [3:0] d7, d6, d5, d4, d3, d2, d1, d0;
  logic [7:0] dp_mask;
  logic       lz_en;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output d7, d6, d5, d4, d3, d2, d1, d0, dp_mask, lz_en,
    input  an, seg, dp
  );

  modport slave (
    input  d7, d6, d5, d4, d3, d2, d1, d0, dp_mask, lz_en,
    output an, seg, dp
  );
endinterface

// File: rtl/seg7_decode.sv
// Combinational hex digit to active-low seven-segment pattern.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);
  assign seg_o = SEG_LUT[digit_i];
endmodule

// File: rtl/seg7_scan.sv
// Eight-digit time-multiplexed display driver with frame-start snapshot,
// per-slot dead time and optional leading-zero blanking; all pins registered.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned DIGIT_CYCLES = 100_000,
  parameter int unsigned BLANK_CYCLES = 2_000
) (
  input logic       clk,
  input logic       rst,
  seg7_scan_if.slave bus
);
  localparam int unsigned CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;

  if (DIGIT_CYCLES < BLANK_CYCLES + 1) begin : g_param_chk
    $error("seg7_scan: DIGIT_CYCLES must be at least BLANK_CYCLES+1");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  shadow_t       shd_q, shd_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          frame_start;
  logic          cnt_wrap;
  logic [7:0]    lz_blank;
  logic          zero_run;
  logic [6:0]    cur_seg;

  assign frame_start = (idx_q == 3'd0) && (cnt_q == '0);
  assign cnt_wrap    = (cnt_q == CW'(DIGIT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
    idx_d = cnt_wrap ? idx_q + 3'd1 : idx_q;
  end

  // Output decode uses the post-capture shadow so a zero dead time still
  // shows freshly captured values on the first slot of the frame.
  always_comb begin
    shd_d = shd_q;
    if (frame_start) begin
      shd_d.dig     = {bus.d7, bus.d6, bus.d5, bus.d4,
                       bus.d3, bus.d2, bus.d1, bus.d0};
      shd_d.dp_mask = bus.dp_mask;
      shd_d.lz_en   = bus.lz_en;
    end
  end

  always_comb begin
    lz_blank = '0;
    zero_run = shd_d.lz_en;
    for (int unsigned k = 0; k < 7; k++) begin
      zero_run = zero_run && (shd_d.dig[3'(7 - k)] == 4'd0);
      lz_blank[3'(7 - k)] = zero_run;
    end
  end

  seg7_decode u_decode (
    .digit_i (shd_d.dig[idx_q]),
    .seg_o   (cur_seg)
  );

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (!(32'(cnt_q) < BLANK_CYCLES) && !lz_blank[idx_q]) begin
      an_d  = ~(8'b1 << idx_q);
      seg_d = cur_seg;
      dp_d  = ~shd_d.dp_mask[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      shd_q <= '0;
      an_q  <= AN_OFF;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shd_q <= shd_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: a cycle-count reference model predicts the
// pins after every edge, a negedge monitor compares them.
module tb_seg7_scan;
  localparam int DC = 8;
  localparam int BC = 2;

  typedef struct {
    int         t;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  exp_t exp_q[$];

  seg7_scan_if bus ();

  seg7_scan #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_ref(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // Reference model: t counts cycles since reset release; the frame is 8*DC
  // cycles, the slot is t/DC mod 8, and digits are snapshotted at t mod 64 == 0.
  int         t_m = 0;
  logic [3:0] sd[8];
  logic [7:0] sdp = '0;
  logic       slz = 1'b0;

  always @(posedge clk) begin
    exp_t e;
    int   slot, pos;
    bit   blanked;
    e.t = t_m;
    e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1;
    if (rst) begin
      t_m = 0;
      for (int i = 0; i < 8; i++) sd[i] = 4'd0;
      sdp = '0; slz = 1'b0;
      e.t = -1;
    end else begin
      if (t_m % (8 * DC) == 0) begin
        sd[0] = bus.d0; sd[1] = bus.d1; sd[2] = bus.d2; sd[3] = bus.d3;
        sd[4] = bus.d4; sd[5] = bus.d5; sd[6] = bus.d6; sd[7] = bus.d7;
        sdp = bus.dp_mask; slz = bus.lz_en;
      end
      slot = (t_m / DC) % 8;
      pos  = t_m % DC;
      blanked = 1'b0;
      if (slz && slot >= 1) begin
        blanked = 1'b1;
        for (int i = slot; i < 8; i++) if (sd[i] != 4'd0) blanked = 1'b0;
      end
      if (pos >= BC && !blanked) begin
        e.an  = ~(8'd1 << slot);
        e.seg = seg_ref(sd[slot]);
        e.dp  = ~sdp[slot];
      end
      t_m++;
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({bus.an, bus.seg, bus.dp} !== {e.an, e.seg, e.dp}) begin
        errors++;
        $display("FAIL pins t=%0d: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                 e.t, bus.an, bus.seg, bus.dp, e.an, e.seg, e.dp);
      end
      checks++;
      if ($countones(~bus.an) > 1) begin
        errors++;
        $display("FAIL one_anode t=%0d: got an=%h, expected at most one low bit", e.t, bus.an);
      end
    end
  end

  task automatic set_digits(input logic [31:0] v);
    {bus.d7, bus.d6, bus.d5, bus.d4, bus.d3, bus.d2, bus.d1, bus.d0} = v;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [31:0] v;
    int nz;
    set_digits(32'h8765_4321);
    bus.dp_mask = 8'h00;
    bus.lz_en   = 1'b0;
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;

    // full scan, then d0 changes at frame cycle 20 of the second frame
    cycles(64 + 20);
    bus.d0 = 4'd9;
    cycles(44 + 64);

    // leading-zero blanking, then all zeros
    set_digits(32'h0000_0105);
    bus.lz_en = 1'b1;
    cycles(128);
    set_digits(32'h0000_0000);
    cycles(128);

    // decimal point on a hex digit
    set_digits(32'h1234_5E78);
    bus.lz_en   = 1'b0;
    bus.dp_mask = 8'h04;
    cycles(128);

    // reset in slot 5 with new inputs queued for the restart
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    cycles(5 * DC + 3);
    set_digits(32'hFEDC_BA98);
    bus.dp_mask = 8'hA5;
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    cycles(128);

    // randomized inputs with occasional resets
    for (int it = 0; it < 40; it++) begin
      nz = $urandom_range(0, 8);
      v = '0;
      for (int k = 0; k < 8; k++)
        if (k < nz) v[k*4 +: 4] = 4'($urandom_range(0, 15));
      set_digits(v);
      bus.dp_mask = 8'($urandom_range(0, 255));
      bus.lz_en   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        cycles($urandom_range(1, 3));
        rst = 1'b0;
      end
      cycles($urandom_range(1, 60));
    end

    cycles(2);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg7_scan.md
# seg7_scan

Time-multiplexed driver for the board's eight-digit common-anode seven-segment display. Consumes the eight 4-bit digit values produced by the stopwatch counter (`d7`..`d0`) and drives the active-low anode and cathode pins. A frame-start snapshot prevents tearing, a per-slot dead time suppresses ghosting, and optional leading-zero blanking is supported. Sits directly downstream of `stopwatch` in the top level.

## Interface
- `DIGIT_CYCLES`, 100_000, clock cycles per digit slot (1 ms at 100 MHz); must be ≥ `BLANK_CYCLES`+1.
- `BLANK_CYCLES`, 2_000, dead-time cycles at the start of each slot with all anodes off; 0 is legal.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `d7`..`d0`  in  4 each  digit values, `d7` leftmost; 0–9 decimal, A–F hex.
- `dp_mask`  in  8  bit i=1 lights the decimal point of digit i.
- `lz_en`  in  1  1 = blank leading zeros.
- `an`  out  8  active-low anode enables; bit i = digit i.
- `seg`  out  7  active-low cathodes `{g,f,e,d,c,b,a}`.
- `dp`  out  1  active-low decimal point.

## Operation
- `cnt` counts 0..`DIGIT_CYCLES`-1 and wraps. `idx` (3 bits) increments on each `cnt` wrap and wraps 7→0.
- Frame start is the cycle with `idx`==0 and `cnt`==0. In that cycle `d7`..`d0`, `dp_mask` and `lz_en` are captured into shadow registers. Mid-frame input changes are invisible until the next frame start.
- Leading-zero blank: with shadow `lz_en`=1, digit i (i≥1) is blanked when every shadow digit from i to 7 is 0. Digit 0 is never blanked.
- Per slot, computed from `cnt`/`idx`/shadow:
  - `cnt` < `BLANK_CYCLES` or digit `idx` blanked → `an`=8'hFF, `seg`=7'h7F, `dp`=1.
  - Otherwise → `an`=~(1<<`idx`), `seg`=decode(shadow digit `idx`), `dp`=~shadow `dp_mask`[`idx`].
- Decode, active-low: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
- Reset values: `cnt`=0, `idx`=0, shadows=0, `an`=8'hFF, `seg`=7'h7F, `dp`=1.
- Reset mid-frame: state returns to reset values on the next edge. The first cycle after release is a frame start and captures fresh inputs.
- At most one anode is low in any cycle. An anode never goes low in the same cycle as a `seg` change: `BLANK_CYCLES`≥1 guarantees this.

## Timing
- All outputs are registered. Pins in cycle k reflect counter/shadow state of cycle k-1.
- Capture latency: values present at frame-start edge F appear on digit 0 pins at F+`BLANK_CYCLES`+1, and on digit i at F+i·`DIGIT_CYCLES`+`BLANK_CYCLES`+1.
- Digit i is lit for `DIGIT_CYCLES`-`BLANK_CYCLES` consecutive cycles per frame. The frame period is 8·`DIGIT_CYCLES`.
- `cnt` and `idx` wrap in the same cycle when both are at their maxima, and that next cycle is a frame start.

## Structure
- Package `seg7_pkg`: `SEG_BLANK`=7'h7F, `AN_OFF`=8'hFF, and a 16-entry `SEG_LUT` constant array with the encodings above.
- Sub-module `seg7_decode` (combinational, 4-bit in → 7-bit out via `SEG_LUT`), instantiated once on the selected shadow digit.
- Top `seg7_scan`: counters, shadows, blank logic and output registers.
- Elaboration-time assertion on the `DIGIT_CYCLES`/`BLANK_CYCLES` relation.

## Test plan
Use `DIGIT_CYCLES`=8, `BLANK_CYCLES`=2.
- **Reset:** hold `rst` 3 cycles → `an`=FF, `seg`=7F, `dp`=1 throughout. After release, `an`=FE first appears at cycle 3.
- **Full scan:** digits 7..0 = 8,7,6,5,4,3,2,1, `lz_en`=0 → slot i shows `an`=~(1<<i) for 6 cycles with the correct `seg` (digit 0 → 79, digit 7 → 00), then `an`=FF for 2 cycles. Frame period is 64 cycles.
- **Snapshot:** change `d0` from 1 to 9 at frame cycle 20 → the remaining slots of the current frame are unchanged. Digit 0 shows 10 only in the next frame.
- **Leading-zero blanking:** digits = 0,0,0,0,0,1,0,5, `lz_en`=1 → `an` stays FF in slots 3..7. Slots 2, 1, 0 show 79, 40, 12. With all-zero digits, only digit 0 lights (40).
- **Decimal point and hex:** `dp_mask`=8'h04, `d2`=4'hE → slot 2 drives `seg`=06 and `dp`=0. `dp`=1 in all other slots.
- **Reset mid-frame:** assert `rst` in slot 5 → outputs go FF/7F/1 on the next edge, and the scan restarts at digit 0 with newly captured inputs.
